stage4_mem_pipe: RTL
====================

# stage4_mem_pipe

Parametrised memory-access stage for the five-stage LoongArch pipeline. It sits between EX and WB and accepts one instruction per cycle from EX. It waits for the data-SRAM-like bus response (`data_ok`) of any request EX issued, buffers that response if WB stalls, aligns and extends loaded data, and forwards the result to decode. It also tracks and silently discards responses that belong to instructions cancelled by an exception or `ertn` flush.

## Interface
Parameters:
- `BUS_W`, 204: width of `es_to_ms_bus`; must be ≥ 78. Bits above 77 are opaque sideband and are passed through to WB unchanged.
- `CNT_W`, 2: width of the discard counter; it must cover the maximum number of outstanding cancelled requests.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: `ertn_flush | wb_ex`; cancels the stage contents.
- `es_to_ms_valid` in 1: EX has an instruction.
- `es_to_ms_bus` in `BUS_W`. Field layout:
  - [31:0] pc
  - [32] gr_we
  - [33] res_from_mem
  - [38:34] dest
  - [70:39] alu_result
  - [72:71] addr_lo
  - [75:73] ld_op (bit0 byte, bit1 half, bit2 signed)
  - [76] req_sent (EX issued a bus request)
  - [77] ex (exception already flagged)
  - [BUS_W-1:78] sideband
- `ms_allow_in` out 1: the stage can accept from EX.
- `ws_allow_in` in 1: WB can accept.
- `ms_to_ws_valid` out 1.
- `ms_to_ws_bus` out `BUS_W-7`: {sideband, ex, final_result[31:0], dest, gr_we, pc}.
- `ms_to_ds_bus` out 39: {fwd_we, dest[4:0], final_result[31:0], load_pending}.
- `ms_ex` out 1: `ms_valid & ex`; EX uses it to suppress later stores.
- `data_sram_data_ok` in 1: bus response strobe.
- `data_sram_rdata` in 32: response data.

## Operation
- Bus register: loads `es_to_ms_bus` when `es_to_ms_valid & ms_allow_in & ~flush`. It holds otherwise and is never zeroed on a stall.
- `ms_valid`:
  - cleared on `flush`;
  - else, when `ms_allow_in`, loads `es_to_ms_valid`.
- Pending condition: `pending = ms_valid & req_sent & ~got`, where `got` is the response-buffer flag.
- Own response: when `pending` and `data_ok` arrive with `discard_cnt == 0`, the data is the stage's own response.
  - The data is used combinationally in the same cycle.
  - If `~ws_allow_in`, the data is written to `rdata_buf` and `got` is set.
- `got` clears when the instruction leaves (`ms_to_ws_valid & ws_allow_in`) or on `flush`.
- `ms_ready_go = ~req_sent | got | (data_ok & discard_cnt == 0)`.
- `ms_allow_in = ~ms_valid | (ms_ready_go & ws_allow_in)`.
- `ms_to_ws_valid = ms_valid & ms_ready_go & ~flush`.
- Discard counter, on `flush`, increments by:
  - +1 if `pending` and no own `data_ok` this cycle;
  - +1 if `es_to_ms_valid` with the incoming bus `req_sent` set.
- The counter decrements by 1 on each `data_ok` while it is nonzero; that response is dropped. Increment and decrement in the same cycle net out.
- Saturation at `2^CNT_W - 1` is illegal; the bench asserts it never happens.
- Result selection:
  - `mem_result` is taken from `got ? rdata_buf : data_sram_rdata`;
  - `final_result = res_from_mem ? mem_result : alu_result`.
- Forwarding:
  - `fwd_we = ms_valid & gr_we`;
  - `load_pending = ms_valid & res_from_mem & ~ms_ready_go`. Decode stalls on a dest match while this is set.

## Timing
- Reset (async) values:
  - `ms_valid` = 0, bus register = 0, `got` = 0, `rdata_buf` = 0, `discard_cnt` = 0;
  - therefore `ms_allow_in` = 1, `ms_to_ws_valid` = 0, `ms_ex` = 0, `ms_to_ds_bus` = 0.
- Latency: no request → 1 cycle EX→WB. With a request, data becomes visible in the cycle of `data_ok`, at the earliest in the cycle the instruction enters MS.
- `flush` takes effect in the same cycle: `ms_to_ws_valid` = 0, and the stage is empty the next cycle.
- `data_ok` in the `flush` cycle while `pending`: it counts as the own response and is not counted for discard.
- Stale `data_ok` while `discard_cnt > 0`: it never satisfies `ms_ready_go`.
- Reset mid-operation: all state clears immediately, and no response is discarded afterwards.

## Configuration
- `MS_SUBWORD_LOAD_EN` defined: byte/half extraction is performed.
  - Byte lane selected by `addr_lo`; half lane by `addr_lo[1]`.
  - Sign-extended if `ld_op[2]`, else zero-extended.
- Undefined: `mem_result = raw word`, and `ld_op`/`addr_lo` are ignored (word loads only).

## Test plan
- ALU op, pc=0x1c000000, alu_result=0x1234, `ws_allow_in`=1 → `ms_to_ws_valid` the next cycle, with final_result 0x1234.
- `ld.b` (ld_op=3'b101), addr_lo=2, rdata=0x00F00000, `data_ok` 3 cycles late → `load_pending`=1 for 3 cycles, then result 0xFFFFFFF0.
- `ld.hu`, addr_lo=2, `data_ok` while `ws_allow_in`=0 for 2 cycles with rdata=0x8001_0000, then the bus changes → the buffered result 0x00008001 is delivered when WB frees.
- `flush` while MS is pending and EX holds req_sent → `discard_cnt`=2. The next two `data_ok` are dropped; the third completes the new load.
- `flush` coinciding with the own `data_ok` → `discard_cnt` stays 0 and `ms_to_ws_valid`=0.
- Assert `reset` with `got`=1, `discard_cnt`=1 → all outputs are at reset values in the same cycle.

Source files
------------

// File: rtl/stage4_mem_pipe.sv
// Memory-access stage: waits for bus data_ok, buffers it across WB stalls,
// aligns loads and drops responses of flushed requests. Macro: MS_SUBWORD_LOAD_EN.
module stage4_mem_pipe #(
    parameter int BUS_W = 204,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             es_to_ms_valid,
    input  logic [BUS_W-1:0] es_to_ms_bus,
    output logic             ms_allow_in,
    input  logic             ws_allow_in,
    output logic             ms_to_ws_valid,
    output logic [BUS_W-8:0] ms_to_ws_bus,
    output logic [38:0]      ms_to_ds_bus,
    output logic             ms_ex,
    input  logic             data_sram_data_ok,
    input  logic [31:0]      data_sram_rdata
);

`ifdef MS_SUBWORD_LOAD_EN
    localparam bit SUBWORD_EN = 1'b1;
`else
    localparam bit SUBWORD_EN = 1'b0;
`endif

    logic             ms_valid;
    logic [BUS_W-1:0] ms_bus;
    logic             got;
    logic [31:0]      rdata_buf;
    logic [CNT_W-1:0] discard_cnt;
    logic [CNT_W-1:0] cnt_next;

    logic [31:0]      pc;
    logic             gr_we;
    logic             res_from_mem;
    logic [4:0]       dest;
    logic [31:0]      alu_result;
    logic [1:0]       addr_lo;
    logic [2:0]       ld_op;
    logic             req_sent;
    logic             ex;
    logic [BUS_W-79:0] sideband;

    assign pc           = ms_bus[31:0];
    assign gr_we        = ms_bus[32];
    assign res_from_mem = ms_bus[33];
    assign dest         = ms_bus[38:34];
    assign alu_result   = ms_bus[70:39];
    assign addr_lo      = ms_bus[72:71];
    assign ld_op        = ms_bus[75:73];
    assign req_sent     = ms_bus[76];
    assign ex           = ms_bus[77];
    assign sideband     = ms_bus[BUS_W-1:78];

    logic cnt_zero;
    logic pending;
    logic own_ok;
    logic ms_ready_go;
    logic fire;
    logic inc_a;
    logic inc_b;
    logic dec;

    assign cnt_zero    = (discard_cnt == '0);
    assign pending     = ms_valid & req_sent & ~got;
    assign own_ok      = pending & data_sram_data_ok & cnt_zero;
    assign ms_ready_go = ~req_sent | got | (data_sram_data_ok & cnt_zero);
    assign ms_allow_in = ~ms_valid | (ms_ready_go & ws_allow_in);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;
    assign fire        = ms_to_ws_valid & ws_allow_in;
    assign ms_ex       = ms_valid & ex;

    // A flushed request still owes one response; count it so it is dropped.
    assign inc_a = flush & pending & ~own_ok;
    assign inc_b = flush & es_to_ms_valid & es_to_ms_bus[76];
    assign dec   = data_sram_data_ok & ~cnt_zero;
    assign cnt_next = discard_cnt + CNT_W'(inc_a) + CNT_W'(inc_b)
                    - CNT_W'(dec);

    logic [31:0] raw_word;
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] sub_result;
    logic [31:0] mem_result;
    logic [31:0] final_result;

    assign raw_word = got ? rdata_buf : data_sram_rdata;
    assign shifted  = raw_word >> {addr_lo, 3'b000};
    assign half     = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

    always_comb begin
        sub_result = raw_word;
        if (ld_op[0])
            sub_result = {{24{ld_op[2] & shifted[7]}}, shifted[7:0]};
        else if (ld_op[1])
            sub_result = {{16{ld_op[2] & half[15]}}, half};
    end

    assign mem_result   = SUBWORD_EN ? sub_result : raw_word;
    assign final_result = res_from_mem ? mem_result : alu_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid    <= 1'b0;
            ms_bus      <= '0;
            got         <= 1'b0;
            rdata_buf   <= '0;
            discard_cnt <= '0;
        end else begin
            if (flush)
                ms_valid <= 1'b0;
            else if (ms_allow_in)
                ms_valid <= es_to_ms_valid;

            if (es_to_ms_valid & ms_allow_in & ~flush)
                ms_bus <= es_to_ms_bus;

            if (flush | fire)
                got <= 1'b0;
            else if (own_ok & ~ws_allow_in)
                got <= 1'b1;

            if (own_ok & ~ws_allow_in)
                rdata_buf <= data_sram_rdata;

            discard_cnt <= cnt_next;
        end
    end

    assign ms_to_ws_bus = {sideband, ex, final_result, dest, gr_we, pc};
    assign ms_to_ds_bus = {ms_valid & gr_we, dest, final_result,
                           ms_valid & res_from_mem & ~ms_ready_go};

endmodule
